// File: rtl/hdmi_pkg.sv
// Shared constants and FSM state type for the HDMI period scheduler.
// Mode encodings, preamble CTL words, period lengths, scheduling thresholds.
package hdmi_pkg;

  localparam logic [2:0] MODE_CTRL         = 3'd0;
  localparam logic [2:0] MODE_VIDEO        = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
  localparam logic [2:0] MODE_ISLAND       = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

  localparam logic [3:0] CTL_NONE = 4'b0000;
  localparam logic [3:0] CTL_VPRE = 4'b0001;
  localparam logic [3:0] CTL_DPRE = 4'b0101;

  localparam logic [5:0] PRE_LEN   = 6'd8;
  localparam logic [5:0] GUARD_LEN = 6'd2;
  localparam logic [5:0] PKT_LEN   = 6'd32;

  localparam int ISLAND_MIN = 58;
  localparam int PKT_MIN    = 49;
  localparam int VPRE_LEAD  = 10;

  typedef enum logic [2:0] {
    ST_CTRL,
    ST_VPRE,
    ST_VGUARD,
    ST_VIDEO,
    ST_DPRE,
    ST_DGUARD_L,
    ST_DATA,
    ST_DGUARD_T
  } state_e;

  function automatic logic [2:0] state_mode(input state_e s);
    logic [2:0] m;
    m = MODE_CTRL;
    unique case (s)
      ST_VGUARD:   m = MODE_VIDEO_GUARD;
      ST_VIDEO:    m = MODE_VIDEO;
      ST_DGUARD_L: m = MODE_ISLAND_GUARD;
      ST_DGUARD_T: m = MODE_ISLAND_GUARD;
      ST_DATA:     m = MODE_ISLAND;
      default:     m = MODE_CTRL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel TMDS period sequencer: control, video preamble/guard, video, data island.
// In: clk_pixel, reset_n, de, blank_left, sync_in, packet_valid. Out: mode, ctl, sync_out, packet_ready/pixel/abort.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int MAX_PACKETS = 18,
  parameter int BLANK_WIDTH = 12
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  input  logic                   de,
  input  logic [BLANK_WIDTH-1:0] blank_left,
  input  logic [1:0]             sync_in,
  input  logic                   packet_valid,
  output logic [2:0]             mode,
  output logic [3:0]             ctl,
  output logic [1:0]             sync_out,
  output logic                   packet_ready,
  output logic [4:0]             packet_pixel,
  output logic                   packet_abort
);

  localparam int PKT_W = $clog2(MAX_PACKETS + 1);

  state_e           state_q, state_d;
  logic [5:0]       phase_q, phase_d;
  logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [3:0]       ctrl_cnt_q, ctrl_cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             ready_q, ready_d;
  logic             abort_q, abort_d;

  logic bl_vpre, bl_island, bl_pkt, more_pkt;

  assign bl_vpre   = blank_left == BLANK_WIDTH'(VPRE_LEAD);
  assign bl_island = blank_left >= BLANK_WIDTH'(ISLAND_MIN);
  assign bl_pkt    = blank_left >= BLANK_WIDTH'(PKT_MIN);
  assign more_pkt  = packet_valid && bl_pkt
                     && (pkt_cnt_q < PKT_W'(MAX_PACKETS));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 6'd1;
    pkt_cnt_d = pkt_cnt_q;
    ready_d   = 1'b0;
    abort_d   = 1'b0;
    sync_d    = sync_in;
    if (de && state_q != ST_VIDEO && state_q != ST_VGUARD) begin
      state_d = ST_VIDEO;
      phase_d = 6'd0;
      abort_d = state_q == ST_DATA;
    end else begin
      unique case (state_q)
        ST_CTRL: begin
          phase_d = 6'd0;
          if (bl_vpre) begin
            state_d = ST_VPRE;
          end else if (packet_valid && ctrl_cnt_q >= 4'd4 && bl_island) begin
            state_d = ST_DPRE;
          end
        end
        ST_VPRE: begin
          if (phase_q == PRE_LEN - 6'd1) begin
            state_d = ST_VGUARD;
            phase_d = 6'd0;
          end
        end
        ST_VGUARD: begin
          if (phase_q == GUARD_LEN - 6'd1) begin
            state_d = ST_VIDEO;
            phase_d = 6'd0;
          end
        end
        ST_VIDEO: begin
          phase_d = 6'd0;
          if (!de) state_d = ST_CTRL;
        end
        ST_DPRE: begin
          if (phase_q == PRE_LEN - 6'd1) begin
            state_d = ST_DGUARD_L;
            phase_d = 6'd0;
          end
        end
        ST_DGUARD_L: begin
          if (phase_q == GUARD_LEN - 6'd1) begin
            state_d   = ST_DATA;
            phase_d   = 6'd0;
            ready_d   = 1'b1;
            pkt_cnt_d = PKT_W'(1);
          end
        end
        ST_DATA: begin
          if (phase_q == PKT_LEN - 6'd1) begin
            phase_d = 6'd0;
            if (more_pkt) begin
              ready_d   = 1'b1;
              pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
            end else begin
              state_d = ST_DGUARD_T;
            end
          end
        end
        ST_DGUARD_T: begin
          if (phase_q == GUARD_LEN - 6'd1) begin
            state_d = ST_CTRL;
            phase_d = 6'd0;
          end
        end
        default: begin
          state_d = ST_CTRL;
          phase_d = 6'd0;
        end
      endcase
    end
    // Packet count only lives inside the data period.
    if (state_d != ST_DATA) pkt_cnt_d = '0;
    ctrl_cnt_d = 4'd0;
    if (state_d == ST_CTRL) begin
      ctrl_cnt_d = (ctrl_cnt_q == 4'd15) ? 4'd15 : ctrl_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q    <= ST_CTRL;
      phase_q    <= 6'd0;
      pkt_cnt_q  <= '0;
      ctrl_cnt_q <= 4'd0;
      sync_q     <= 2'd0;
      ready_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      sync_q     <= sync_d;
      ready_q    <= ready_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    mode = state_mode(state_q);
    ctl  = CTL_NONE;
    if (state_q == ST_VPRE) ctl = CTL_VPRE;
    if (state_q == ST_DPRE) ctl = CTL_DPRE;
    packet_pixel = (state_q == ST_DATA) ? phase_q[4:0] : 5'd0;
  end

  assign sync_out     = sync_q;
  assign packet_ready = ready_q;
  assign packet_abort = abort_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler, default and MAX_PACKETS=2 instances.
// Checks outputs one pixel clock after each pixel's inputs.
`timescale 1ns/1ps
module tb_hdmi_period_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        de;
  logic [11:0] blank_left;
  logic [1:0]  sync_in;
  logic        packet_valid;

  logic [2:0] mode, mode2;
  logic [3:0] ctl, ctl2;
  logic [1:0] sync_out, sync_out2;
  logic       packet_ready, packet_ready2;
  logic [4:0] packet_pixel, packet_pixel2;
  logic       packet_abort, packet_abort2;

  int errors = 0;
  int checks = 0;
  int rdy_cnt;
  int em, ec, ep, er;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_period_scheduler dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .de(de),
    .blank_left(blank_left), .sync_in(sync_in),
    .packet_valid(packet_valid), .mode(mode), .ctl(ctl),
    .sync_out(sync_out), .packet_ready(packet_ready),
    .packet_pixel(packet_pixel), .packet_abort(packet_abort)
  );

  hdmi_period_scheduler #(.MAX_PACKETS(2)) dut2 (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .de(de),
    .blank_left(blank_left), .sync_in(sync_in),
    .packet_valid(packet_valid), .mode(mode2), .ctl(ctl2),
    .sync_out(sync_out2), .packet_ready(packet_ready2),
    .packet_pixel(packet_pixel2), .packet_abort(packet_abort2)
  );

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input int b,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s b=%0d observed=%0d expected=%0d", tag, b, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; de = 1'b0; packet_valid = 1'b0;
    blank_left = 12'd0; sync_in = 2'd3;
    step();
    reset_n = 1'b1;
  endtask

  // Expected outputs for a 100-pixel blank starting right after reset.
  task automatic exp100(input int b, input bit ext);
    em = 0; ec = 0; ep = 0; er = 0;
    if (b >= 97)               begin em = 0; end
    else if (b >= 89)          begin ec = 5; end
    else if (b >= 87)          begin em = 4; end
    else if (b >= 55)          begin em = 3; ep = 86 - b; end
    else if (ext && b >= 23)   begin em = 3; ep = 54 - b; end
    else if (ext && b >= 21)   begin em = 4; end
    else if (!ext && b >= 53)  begin em = 4; end
    else if (b >= 11)          begin em = 0; end
    else if (b >= 3)           begin ec = 1; end
    else                       begin em = 2; end
    er = (b == 86 || (ext && b == 54)) ? 1 : 0;
  endtask

  task automatic run100(input bit ext);
    do_reset();
    packet_valid = 1'b1;
    rdy_cnt = 0;
    for (int b = 100; b >= 1; b--) begin
      blank_left = 12'(b);
      sync_in = 2'(b);
      step();
      exp100(b, ext);
      chk("mode", b, 32'(mode), 32'(em));
      chk("ctl", b, 32'(ctl), 32'(ec));
      chk("pixel", b, 32'(packet_pixel), 32'(ep));
      chk("ready", b, 32'(packet_ready), 32'(er));
      chk("sync", b, 32'(sync_out), 32'(b % 4));
      if (packet_ready) rdy_cnt++;
      if (!ext && packet_ready) packet_valid = 1'b0;
    end
    de = 1'b1;
    step();
    chk("video", 0, 32'(mode), 32'd1);
    chk("rdy_total", 0, 32'(rdy_cnt), ext ? 32'd2 : 32'd1);
    de = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; de = 1'b0; packet_valid = 1'b0;
    blank_left = 12'd0; sync_in = 2'd3;
    step();
    step();
    chk("rst_mode", 0, 32'(mode), 32'd0);
    chk("rst_ctl", 0, 32'(ctl), 32'd0);
    chk("rst_sync", 0, 32'(sync_out), 32'd0);
    chk("rst_ready", 0, 32'(packet_ready), 32'd0);
    chk("rst_abort", 0, 32'(packet_abort), 32'd0);
    chk("rst_pixel", 0, 32'(packet_pixel), 32'd0);

    run100(1'b0);
    run100(1'b1);

    // MAX_PACKETS=2: third packet refused on dut2, granted on dut.
    do_reset();
    packet_valid = 1'b1;
    rdy_cnt = 0;
    for (int b = 400; b >= 1; b--) begin
      blank_left = 12'(b);
      step();
      if (b >= 321 && packet_ready2) rdy_cnt++;
      if (b == 323) chk("max_last", b, 32'(mode2), 32'd3);
      if (b == 322) chk("max_gt", b, 32'(mode2), 32'd4);
      if (b == 322) chk("max_def", b, 32'(mode), 32'd3);
      if (b == 322) chk("max_defrdy", b, 32'(packet_ready), 32'd1);
      if (b == 320) chk("max_ctrl", b, 32'(mode2), 32'd0);
    end
    chk("max_rdy", 0, 32'(rdy_cnt), 32'd2);

    // Short blank: no island, only the video preamble.
    do_reset();
    packet_valid = 1'b1;
    for (int b = 57; b >= 1; b--) begin
      blank_left = 12'(b);
      step();
      chk("short_mode", b, 32'(mode), (b <= 2) ? 32'd2 : 32'd0);
      chk("short_ctl", b, 32'(ctl),
          (b <= 10 && b >= 3) ? 32'd1 : 32'd0);
      chk("short_rdy", b, 32'(packet_ready), 32'd0);
    end

    // Early de during a packet.
    do_reset();
    packet_valid = 1'b1;
    for (int b = 100; b >= 74; b--) begin
      blank_left = 12'(b);
      step();
      chk("early_abort0", b, 32'(packet_abort), 32'd0);
    end
    chk("early_pix12", 74, 32'(packet_pixel), 32'd12);
    de = 1'b1;
    step();
    chk("early_mode", 73, 32'(mode), 32'd1);
    chk("early_abort", 73, 32'(packet_abort), 32'd1);
    chk("early_pixel", 73, 32'(packet_pixel), 32'd0);
    step();
    chk("early_abort_end", 72, 32'(packet_abort), 32'd0);
    chk("early_vid", 72, 32'(mode), 32'd1);
    de = 1'b0;
    blank_left = 12'd50;
    step();
    chk("early_ctrl", 50, 32'(mode), 32'd0);

    // Reset in the middle of a packet.
    do_reset();
    packet_valid = 1'b1;
    for (int b = 100; b >= 70; b--) begin
      blank_left = 12'(b);
      sync_in = 2'd2;
      step();
    end
    chk("mid_data", 70, 32'(mode), 32'd3);
    reset_n = 1'b0;
    blank_left = 12'd69;
    step();
    chk("mid_rst_mode", 69, 32'(mode), 32'd0);
    chk("mid_rst_ctl", 69, 32'(ctl), 32'd0);
    chk("mid_rst_sync", 69, 32'(sync_out), 32'd0);
    chk("mid_rst_ready", 69, 32'(packet_ready), 32'd0);
    chk("mid_rst_abort", 69, 32'(packet_abort), 32'd0);
    chk("mid_rst_pixel", 69, 32'(packet_pixel), 32'd0);
    reset_n = 1'b1;
    for (int b = 68; b >= 63; b--) begin
      blank_left = 12'(b);
      step();
      chk("post_rst_ctl", b, 32'(ctl), (b <= 64) ? 32'd5 : 32'd0);
      chk("post_rst_abort", b, 32'(packet_abort), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
